instr_fetch_unit: RTL and testbench

//   Instruction fetch stage feeding the decoder. Master on the instruction bus (Wishbone classic,
//   one outstanding request), prefetch FIFO of fetched words tagged with their PC, valid/ready

---
 rtl/instr_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: Wishbone classic bus master with one outstanding
// request, a small prefetch FIFO of {word, pc, fault} entries, and a
// valid/ready handshake towards decode. PC redirects flush stale work.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ibus_cyc_o,
  output logic        ibus_stb_o,
  output logic [31:0] ibus_adr_o,
  input  logic [31:0] ibus_dat_i,
  input  logic        ibus_ack_i,
  input  logic        ibus_err_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // FETCH: normal prefetch; DRAIN: swallow the response of a request made
  // stale by a redirect; FAULT: bus error delivered, wait for a redirect.
  typedef enum logic [1:0] {FETCH, DRAIN, FAULT} state_t;

  state_t        state, state_next;
  logic          cyc, cyc_next;
  logic [31:0]   adr, adr_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   target_pc;

  logic [31:0]   mem_data  [FIFO_DEPTH];
  logic [31:0]   mem_pc    [FIFO_DEPTH];
  logic          mem_fault [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_after_pop;

  logic          completing;
  logic          push, pop, flush;
  logic [31:0]   push_data;
  logic          push_fault;
  logic          unused_pc_bits;

  assign target_pc      = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign completing      = cyc & (ibus_ack_i | ibus_err_i);
  assign instr_valid     = (count != '0);
  // A redirect in the same cycle wins over the decoder's pop.
  assign pop             = instr_valid & instr_ready & ~redirect_valid;
  assign count_after_pop = count - CW'(pop);

  assign ibus_cyc_o = cyc;
  assign ibus_stb_o = cyc;
  assign ibus_adr_o = adr;

  // Head entry is gated by valid so the interface reads zero when empty.
  assign instr_data  = instr_valid ? mem_data[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]   : 32'h0;
  assign instr_fault = instr_valid & mem_fault[rd_ptr];

  // Next-state, bus request and FIFO push decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_next    = state;
    cyc_next      = cyc;
    adr_next      = adr;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    push_data     = ibus_dat_i;
    push_fault    = 1'b0;
    flush         = 1'b0;

    if (redirect_valid) begin
      flush         = 1'b1;
      fetch_pc_next = target_pc;
      if (cyc && !completing) begin
        state_next = DRAIN;            // keep the bus cycle until it ends
      end else begin
        state_next = FETCH;
        cyc_next   = 1'b1;
        adr_next   = target_pc;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (completing) begin
            push = 1'b1;
            if (ibus_err_i) begin        // err wins over a simultaneous ack
              push_data  = 32'h0;
              push_fault = 1'b1;
              state_next = FAULT;
              cyc_next   = 1'b0;
            end else begin
              fetch_pc_next = fetch_pc + 32'd4;
              // The slot being filled now plus the next request must fit.
              if ((count_after_pop + CW'(1)) < DEPTH_C) begin
                cyc_next = 1'b1;
                adr_next = fetch_pc + 32'd4;
              end else begin
                cyc_next = 1'b0;
              end
            end
          end else if (!cyc && (count_after_pop < DEPTH_C)) begin
            cyc_next = 1'b1;
            adr_next = fetch_pc;
          end
        end
        DRAIN: begin
          if (completing) begin            // response discarded
            state_next = FETCH;
            cyc_next   = 1'b1;
            adr_next   = fetch_pc;
          end
        end
        FAULT: begin
          cyc_next = 1'b0;
        end
        default: begin
          state_next = FETCH;
          cyc_next   = 1'b0;
        end
      endcase
    end
  end

  // Control state, bus request registers and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      cyc      <= 1'b0;
      adr      <= RESET_PC;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values computed above.
      state    <= state_next;
      cyc      <= cyc_next;
      adr      <= adr_next;
      fetch_pc <= fetch_pc_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_after_pop + CW'(push);
      end
    end
  end

  // FIFO storage write port.
  // NOTE: storage is deliberately not reset; count alone decides validity
  // and the outputs are gated with it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= push_data;
      mem_pc[wr_ptr]    <= adr;
      mem_fault[wr_ptr] <= push_fault;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a Wishbone slave model answers
// requests; every response the fetch unit must keep is pushed to a
// scoreboard queue and compared when decode pops it.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_cyc_o, ibus_stb_o;
  logic [31:0] ibus_adr_o;
  logic [31:0] ibus_dat_i = 32'h0;
  logic        ibus_ack_i = 1'b0;
  logic        ibus_err_i = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data, instr_pc;
  logic        instr_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_cyc_o(ibus_cyc_o), .ibus_stb_o(ibus_stb_o), .ibus_adr_o(ibus_adr_o),
    .ibus_dat_i(ibus_dat_i), .ibus_ack_i(ibus_ack_i), .ibus_err_i(ibus_err_i),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_fault(instr_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } entry_t;

  entry_t      sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cnt = 0;
  int          resp_count = 0;
  int          pop_count = 0;
  bit          stale = 1'b0;
  bit          hold = 1'b0;
  logic [31:0] hold_adr = 32'h0;
  logic [31:0] err_adr = 32'h1;
  logic [31:0] exp_adr = 32'h0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  // Slave response for the current cycle: one wait cycle per request.
  task automatic slave_step();
    bit resp_prev;
    resp_prev  = ibus_ack_i | ibus_err_i;
    ibus_ack_i = 1'b0;
    ibus_err_i = 1'b0;
    ibus_dat_i = 32'h0;
    if (!ibus_cyc_o || !rst_n) begin
      cnt = 0;
    end else if (!resp_prev && cnt >= 1 && !(hold && ibus_adr_o == hold_adr)) begin
      resp_count++;
      cnt = 0;
      if (stale) begin
        stale      = 1'b0;
        ibus_ack_i = 1'b1;
        ibus_dat_i = 32'hDEAD_BEEF;
      end else begin
        checks++;
        if (ibus_adr_o !== exp_adr) begin
          errors++;
          $display("FAIL bus_adr: got %h, expected %h", ibus_adr_o, exp_adr);
        end
        if (ibus_adr_o == err_adr) begin
          ibus_err_i = 1'b1;
          ibus_dat_i = 32'hBAD0_BAD0;
          sb.push_back('{exp_adr, 32'h0, 1'b1});
        end else begin
          ibus_ack_i = 1'b1;
          ibus_dat_i = word_at(ibus_adr_o);
          sb.push_back('{exp_adr, word_at(exp_adr), 1'b0});
          exp_adr = exp_adr + 32'd4;
        end
      end
    end else begin
      cnt = resp_prev ? 1 : cnt + 1;
    end
  endtask

  // One clock: scoreboard compare at the falling edge, then slave update.
  task automatic tick();
    entry_t e;
    @(negedge clk);
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      pop_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc=%h data=%h, expected no entry", instr_pc, instr_data);
      end else begin
        e = sb.pop_front();
        if (instr_pc !== e.pc || instr_data !== e.data || instr_fault !== e.fault) begin
          errors++;
          $display("FAIL pop_entry: got pc=%h data=%h fault=%b, expected pc=%h data=%h fault=%b",
                   instr_pc, instr_data, instr_fault, e.pc, e.data, e.fault);
        end
      end
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    slave_step();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb.delete();
    if (ibus_cyc_o && !(ibus_ack_i || ibus_err_i)) stale = 1'b1;
    exp_adr = {pc[31:2], 2'b00};
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ibus_ack_i     = 1'b0;
    ibus_err_i     = 1'b0;
    ibus_dat_i     = 32'h0;
    sb.delete();
    stale   = 1'b0;
    hold    = 1'b0;
    err_adr = 32'h1;
    exp_adr = 32'h0;
    cnt     = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ibus_cyc_o !== 1'b0 || ibus_stb_o !== 1'b0 || ibus_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got cyc=%b stb=%b adr=%h, expected 0 0 00000000", ibus_cyc_o, ibus_stb_o, ibus_adr_o);
    end
    checks++;
    if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0 || instr_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_instr: got valid=%b data=%h pc=%h fault=%b, expected all 0", instr_valid, instr_data, instr_pc, instr_fault);
    end
    apply_reset();
    tick();
    checks++;
    if (ibus_cyc_o !== 1'b1 || ibus_stb_o !== 1'b1 || ibus_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL first_request: got cyc=%b stb=%b adr=%h, expected 1 1 00000000", ibus_cyc_o, ibus_stb_o, ibus_adr_o);
    end
  endtask

  task automatic test_stream();
    int p0;
    apply_reset();
    instr_ready = 1'b1;
    repeat (6) tick();
    p0 = pop_count;
    repeat (20) tick();
    checks++;
    if (pop_count - p0 != 10) begin
      errors++;
      $display("FAIL stream_rate: got %0d pops in 20 cycles, expected 10", pop_count - p0);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    apply_reset();
    r0 = resp_count;
    repeat (15) tick();
    checks++;
    if (resp_count - r0 != 2 || ibus_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_requests: got %0d requests cyc=%b, expected 2 requests cyc=0", resp_count - r0, ibus_cyc_o);
    end
    repeat (3) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== 32'h13) begin
      errors++;
      $display("FAIL bp_head_stable: got valid=%b pc=%h data=%h, expected 1 00000000 00000013", instr_valid, instr_pc, instr_data);
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (ibus_cyc_o !== 1'b1 || ibus_adr_o !== 32'h8) begin
      errors++;
      $display("FAIL bp_resume: got cyc=%b adr=%h, expected 1 00000008", ibus_cyc_o, ibus_adr_o);
    end
    repeat (6) tick();
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    instr_ready = 1'b1;
    hold_adr    = 32'h8;
    hold        = 1'b1;
    for (int i = 0; i < 20 && !(ibus_cyc_o && ibus_adr_o == 32'h8); i++) tick();
    repeat (5) tick();
    checks++;
    if (ibus_cyc_o !== 1'b1 || ibus_adr_o !== 32'h8) begin
      errors++;
      $display("FAIL stall_hold: got cyc=%b adr=%h, expected 1 00000008", ibus_cyc_o, ibus_adr_o);
    end
    do_redirect(32'h0000_0103);
    tick();
    checks++;
    if (instr_valid !== 1'b0 || ibus_cyc_o !== 1'b1 || ibus_adr_o !== 32'h8) begin
      errors++;
      $display("FAIL drain_hold: got valid=%b cyc=%b adr=%h, expected 0 1 00000008", instr_valid, ibus_cyc_o, ibus_adr_o);
    end
    hold = 1'b0;
    tick();
    tick();
    checks++;
    if (instr_valid !== 1'b0 || ibus_cyc_o !== 1'b1 || ibus_adr_o !== 32'h100) begin
      errors++;
      $display("FAIL drain_exit: got valid=%b cyc=%b adr=%h, expected 0 1 00000100", instr_valid, ibus_cyc_o, ibus_adr_o);
    end
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
      errors++;
      $display("FAIL redirect_target: got valid=%b pc=%h, expected 1 00000100", instr_valid, instr_pc);
    end
    repeat (4) tick();
  endtask

  task automatic test_fault();
    int bad;
    apply_reset();
    instr_ready = 1'b1;
    err_adr     = 32'h20;
    for (int i = 0; i < 40 && !(instr_valid && instr_fault); i++) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_fault !== 1'b1 || instr_pc !== 32'h20 || instr_data !== 32'h0) begin
      errors++;
      $display("FAIL fault_entry: got valid=%b fault=%b pc=%h data=%h, expected 1 1 00000020 00000000",
               instr_valid, instr_fault, instr_pc, instr_data);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ibus_cyc_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fault_quiet: got cyc=1 in %0d cycles, expected 0", bad);
    end
    err_adr = 32'h1;
    do_redirect(32'h200);
    tick();
    checks++;
    if (ibus_cyc_o !== 1'b1 || ibus_adr_o !== 32'h200) begin
      errors++;
      $display("FAIL fault_exit: got cyc=%b adr=%h, expected 1 00000200", ibus_cyc_o, ibus_adr_o);
    end
    repeat (6) tick();
  endtask

  task automatic test_redirect_ack();
    apply_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 40 && !(ibus_cyc_o && ibus_adr_o == 32'hC && ibus_ack_i); i++) tick();
    checks++;
    if (!(ibus_cyc_o && ibus_adr_o == 32'hC && ibus_ack_i)) begin
      errors++;
      $display("FAIL coincide_setup: got cyc=%b adr=%h ack=%b, expected 1 0000000c 1", ibus_cyc_o, ibus_adr_o, ibus_ack_i);
    end
    do_redirect(32'h40);
    tick();
    checks++;
    if (instr_valid !== 1'b0 || ibus_cyc_o !== 1'b1 || ibus_adr_o !== 32'h40) begin
      errors++;
      $display("FAIL coincide_result: got valid=%b cyc=%b adr=%h, expected 0 1 00000040", instr_valid, ibus_cyc_o, ibus_adr_o);
    end
    repeat (6) tick();
  endtask

  task automatic test_wrap_and_async_reset();
    do_redirect(32'hFFFF_FFFC);
    tick();
    for (int i = 0; i < 20 && !(ibus_cyc_o && ibus_adr_o == 32'h0); i++) tick();
    checks++;
    if (ibus_cyc_o !== 1'b1 || ibus_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_adr: got cyc=%b adr=%h, expected 1 00000000", ibus_cyc_o, ibus_adr_o);
    end
    instr_ready = 1'b0;
    for (int i = 0; i < 20 && !(ibus_cyc_o && instr_valid); i++) tick();
    checks++;
    if (ibus_cyc_o !== 1'b1 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_setup: got cyc=%b valid=%b, expected 1 1", ibus_cyc_o, instr_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ibus_cyc_o !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got cyc=%b valid=%b, expected 0 0", ibus_cyc_o, instr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stall();
    test_fault();
    test_redirect_ack();
    test_wrap_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
